// File: rtl/channel_reader_core.sv
// channel_reader_core: issues one INCR AXI read burst per command and pairs 256-bit R beats into 512-bit output words.
// Latency: output word registered one cycle after each odd beat; odd beats stall on output backpressure, even beats never do.
// Define CHANNEL_READER_ADDR_ALIGN_EN to align io_ar_bits_addr down to the burst size.
module channel_reader_core #(
  parameter int AR_ID = 0,
  parameter int BEATS = 16
) (
  input  logic         clock,
  input  logic         reset,
  // AXI read-address channel
  output logic         io_ar_valid,
  input  logic         io_ar_ready,
  output logic [32:0]  io_ar_bits_addr,
  output logic [1:0]   io_ar_bits_burst,
  output logic [3:0]   io_ar_bits_cache,
  output logic [5:0]   io_ar_bits_id,
  output logic [3:0]   io_ar_bits_len,
  output logic         io_ar_bits_lock,
  output logic [2:0]   io_ar_bits_prot,
  output logic [3:0]   io_ar_bits_qos,
  output logic [3:0]   io_ar_bits_region,
  output logic [2:0]   io_ar_bits_size,
  // AXI read-data channel
  input  logic         io_r_valid,
  output logic         io_r_ready,
  input  logic [255:0] io_r_bits_data,
  input  logic         io_r_bits_last,
  input  logic [1:0]   io_r_bits_resp,
  input  logic [5:0]   io_r_bits_id,
  // read command
  input  logic         io_cmd_in_valid,
  output logic         io_cmd_in_ready,
  input  logic [63:0]  io_cmd_in_bits_addr,
  // packed output stream
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [511:0] io_out_bits_data,
  output logic         io_out_bits_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
  localparam int         ALIGN_W   = $clog2(BEATS * 32);

  state_t         state_q;
  state_t         state_d;
  logic [3:0]     beat_q;
  logic [32:0]    addr_q;
  logic [255:0]   low_q;
  logic           out_valid_q;
  logic [511:0]   out_data_q;
  logic           out_last_q;

  logic           cmd_ready;
  logic           ar_valid;
  logic           r_ready;
  logic           cmd_fire;
  logic           r_fire;
  logic           final_beat;

  assign cmd_fire   = io_cmd_in_valid && cmd_ready;
  assign r_fire     = io_r_valid && r_ready;
  assign final_beat = (beat_q == LAST_BEAT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (io_cmd_in_valid) state_d = AR;
      end
      AR: begin
        ar_valid = 1'b1;
        if (io_ar_ready) state_d = RD;
      end
      RD: begin
        // An odd beat completes a word, so it may only land when the output slot frees up this cycle.
        r_ready = !beat_q[0] || !out_valid_q || io_out_ready;
        if (io_r_valid && r_ready && final_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      cmd_ready = 1'b0;
      r_ready   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q      <= '0;
      addr_q      <= '0;
      low_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (cmd_fire) addr_q <= io_cmd_in_bits_addr[32:0];

      if (r_fire) begin
        beat_q <= final_beat ? 4'd0 : beat_q + 4'd1;
        if (!beat_q[0]) low_q <= io_r_bits_data;
      end

      // A load in the same cycle as a drain replaces the word with no bubble.
      if (r_fire && beat_q[0]) begin
        out_valid_q <= 1'b1;
        out_data_q  <= {io_r_bits_data, low_q};
        out_last_q  <= final_beat;
      end else if (io_out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef CHANNEL_READER_ADDR_ALIGN_EN
  localparam logic [32:0] ALIGN_MASK = ~((33'd1 << ALIGN_W) - 33'd1);
  assign io_ar_bits_addr = addr_q & ALIGN_MASK;
`else
  assign io_ar_bits_addr = addr_q;
`endif

  assign io_ar_valid       = ar_valid;
  assign io_ar_bits_burst  = 2'b01;
  assign io_ar_bits_cache  = 4'd0;
  assign io_ar_bits_id     = 6'(AR_ID);
  assign io_ar_bits_len    = LAST_BEAT;
  assign io_ar_bits_lock   = 1'b0;
  assign io_ar_bits_prot   = 3'd0;
  assign io_ar_bits_qos    = 4'd0;
  assign io_ar_bits_region = 4'd0;
  assign io_ar_bits_size   = 3'd5;

  assign io_r_ready        = r_ready;
  assign io_cmd_in_ready   = cmd_ready;
  assign io_out_valid      = out_valid_q;
  assign io_out_bits_data  = out_data_q;
  assign io_out_bits_last  = out_last_q;

  // Burst end is defined by the beat count alone; R sideband and upper command bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{io_cmd_in_bits_addr[63:33], io_r_bits_last, io_r_bits_resp, io_r_bits_id};

endmodule

// File: tb/tb_channel_reader_core.sv
// Directed bench for channel_reader_core: AXI slave model, expected-word scoreboard, reset/stall/address cases.
module tb_channel_reader_core;

  logic         clock;
  logic         reset;
  logic         io_ar_valid;
  logic         io_ar_ready;
  logic [32:0]  io_ar_bits_addr;
  logic [1:0]   io_ar_bits_burst;
  logic [3:0]   io_ar_bits_cache;
  logic [5:0]   io_ar_bits_id;
  logic [3:0]   io_ar_bits_len;
  logic         io_ar_bits_lock;
  logic [2:0]   io_ar_bits_prot;
  logic [3:0]   io_ar_bits_qos;
  logic [3:0]   io_ar_bits_region;
  logic [2:0]   io_ar_bits_size;
  logic         io_r_valid;
  logic         io_r_ready;
  logic [255:0] io_r_bits_data;
  logic         io_r_bits_last;
  logic [1:0]   io_r_bits_resp;
  logic [5:0]   io_r_bits_id;
  logic         io_cmd_in_valid;
  logic         io_cmd_in_ready;
  logic [63:0]  io_cmd_in_bits_addr;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [511:0] io_out_bits_data;
  logic         io_out_bits_last;

  channel_reader_core dut (
    .clock              (clock),
    .reset              (reset),
    .io_ar_valid        (io_ar_valid),
    .io_ar_ready        (io_ar_ready),
    .io_ar_bits_addr    (io_ar_bits_addr),
    .io_ar_bits_burst   (io_ar_bits_burst),
    .io_ar_bits_cache   (io_ar_bits_cache),
    .io_ar_bits_id      (io_ar_bits_id),
    .io_ar_bits_len     (io_ar_bits_len),
    .io_ar_bits_lock    (io_ar_bits_lock),
    .io_ar_bits_prot    (io_ar_bits_prot),
    .io_ar_bits_qos     (io_ar_bits_qos),
    .io_ar_bits_region  (io_ar_bits_region),
    .io_ar_bits_size    (io_ar_bits_size),
    .io_r_valid         (io_r_valid),
    .io_r_ready         (io_r_ready),
    .io_r_bits_data     (io_r_bits_data),
    .io_r_bits_last     (io_r_bits_last),
    .io_r_bits_resp     (io_r_bits_resp),
    .io_r_bits_id       (io_r_bits_id),
    .io_cmd_in_valid    (io_cmd_in_valid),
    .io_cmd_in_ready    (io_cmd_in_ready),
    .io_cmd_in_bits_addr(io_cmd_in_bits_addr),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_bits_data   (io_out_bits_data),
    .io_out_bits_last   (io_out_bits_last)
  );

  int checks = 0;
  int errors = 0;

  // handshakes seen at the last falling edge (i.e. those that complete at the next rising edge)
  logic ar_fire_s  = 1'b0;
  logic r_fire_s   = 1'b0;
  logic cmd_fire_s = 1'b0;

  // slave model and scoreboard state
  logic         rnd_mode    = 1'b0;
  logic         slv_active  = 1'b0;
  logic         slv_stale   = 1'b0;
  int           slv_beat    = 0;
  int           slv_base    = 0;
  int           cur_base    = 0;
  int           ar_count    = 0;
  int           outstanding = 0;
  int           out_words   = 0;
  int           lasts       = 0;
  logic [32:0]  exp_ar_addr = '0;
  logic [512:0] exp_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One cycle of stimulus: advance the R slave on the handshakes just completed, redrive inputs.
  task automatic tick();
    @(posedge clock);
    #1;
    if (ar_fire_s) begin
      slv_active = 1'b1;
      slv_stale  = 1'b0;
      slv_beat   = 0;
      slv_base   = cur_base;
    end else if (r_fire_s) begin
      slv_beat++;
      if (slv_beat == 16) slv_active = 1'b0;
    end
    io_r_valid     = slv_active;
    io_r_bits_data = 256'(slv_base + slv_beat);
    io_r_bits_last = (slv_beat == 15);
    io_r_bits_resp = 2'($urandom);
    io_r_bits_id   = 6'($urandom);
    io_ar_ready    = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    io_out_ready   = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [32:0] exp_a);
    int n = 0;
    exp_ar_addr         = exp_a;
    io_cmd_in_valid     = 1'b1;
    io_cmd_in_bits_addr = a;
    do begin
      tick();
      n++;
    end while (!cmd_fire_s && n < 2000);
    io_cmd_in_valid     = 1'b0;
    io_cmd_in_bits_addr = '0;
    chk("cmd_accept", 512'(cmd_fire_s), 512'(1));
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (out_words < target && n < 3000) begin
      tick();
      n++;
    end
    chk("word_count", 512'(out_words), 512'(target));
  endtask

  // Monitor: protocol rules and scoreboard, sampled on the falling edge.
  initial begin
    logic [512:0] e;
    logic         ar_wait_p   = 1'b0;
    logic [32:0]  ar_addr_p   = '0;
    logic         out_stall_p = 1'b0;
    logic [511:0] out_data_p  = '0;
    logic         out_last_p  = 1'b0;
    forever begin
      @(negedge clock);
      ar_fire_s  = 1'b0;
      r_fire_s   = 1'b0;
      cmd_fire_s = 1'b0;
      if (!reset) begin
        cmd_fire_s = io_cmd_in_valid && io_cmd_in_ready;
        if (ar_wait_p && io_ar_valid) chk("ar_addr_hold", 512'(io_ar_bits_addr), 512'(ar_addr_p));
        if (out_stall_p && io_out_valid) begin
          chk("out_data_hold", io_out_bits_data, out_data_p);
          chk("out_last_hold", 512'(io_out_bits_last), 512'(out_last_p));
        end
        if (slv_active && !slv_stale) begin
          if (slv_beat % 2 == 0) chk("r_ready_even", 512'(io_r_ready), 512'(1));
          else if (io_out_valid && !io_out_ready) chk("r_ready_stall", 512'(io_r_ready), 512'(0));
        end
        if (io_ar_valid && io_ar_ready) begin
          ar_fire_s = 1'b1;
          chk("ar_single", 512'(outstanding), 512'(0));
          chk("ar_addr", 512'(io_ar_bits_addr), 512'(exp_ar_addr));
          chk("ar_fields",
              512'({io_ar_bits_len, io_ar_bits_size, io_ar_bits_burst, io_ar_bits_id, io_ar_bits_cache,
                    io_ar_bits_lock, io_ar_bits_prot, io_ar_bits_qos, io_ar_bits_region}),
              512'({4'd15, 3'd5, 2'd1, 6'd0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0}));
          cur_base = ar_count * 16;
          for (int k = 0; k < 8; k++)
            exp_q.push_back({(k == 7), 256'(cur_base + 2 * k + 1), 256'(cur_base + 2 * k)});
          outstanding = 1;
          ar_count++;
        end
        if (io_r_valid && io_r_ready) begin
          r_fire_s = 1'b1;
          if (slv_beat == 15) outstanding = 0;
        end
        if (io_out_valid && io_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("out_extra_word", 512'(1), 512'(0));
          end else begin
            e = exp_q.pop_front();
            chk("out_data", io_out_bits_data, e[511:0]);
            chk("out_last", 512'(io_out_bits_last), 512'(e[512]));
          end
          out_words++;
          if (io_out_bits_last) lasts++;
        end
      end
      ar_wait_p   = !reset && io_ar_valid && !io_ar_ready;
      ar_addr_p   = io_ar_bits_addr;
      out_stall_p = !reset && io_out_valid && !io_out_ready;
      out_data_p  = io_out_bits_data;
      out_last_p  = io_out_bits_last;
    end
  end

  initial begin
    int n;
    int base_words;
    reset               = 1'b1;
    io_ar_ready         = 1'b0;
    io_r_valid          = 1'b0;
    io_r_bits_data      = '0;
    io_r_bits_last      = 1'b0;
    io_r_bits_resp      = '0;
    io_r_bits_id        = '0;
    io_cmd_in_valid     = 1'b0;
    io_cmd_in_bits_addr = '0;
    io_out_ready        = 1'b0;

    // reset state
    for (int i = 0; i < 100; i++) tick();
    chk("rst_cmd_ready", 512'(io_cmd_in_ready), 512'(0));
    chk("rst_r_ready", 512'(io_r_ready), 512'(0));
    chk("rst_ar_valid", 512'(io_ar_valid), 512'(0));
    chk("rst_out_valid", 512'(io_out_valid), 512'(0));
    chk("rst_out_last", 512'(io_out_bits_last), 512'(0));
    chk("rst_out_data", io_out_bits_data, 512'(0));
    chk("rst_ar_addr", 512'(io_ar_bits_addr), 512'(0));
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", 512'(io_cmd_in_ready), 512'(1));
    chk("idle_ar_valid", 512'(io_ar_valid), 512'(0));

    // single command, incrementing beats, output always ready
    send_cmd(64'h0, 33'h0);
    wait_words(8);
    chk("single_lasts", 512'(lasts), 512'(1));
    chk("single_ars", 512'(ar_count), 512'(1));

    // three back-to-back commands
    send_cmd(64'h0, 33'h0);
    send_cmd(64'h0, 33'h0);
    send_cmd(64'h0, 33'h0);
    wait_words(32);
    chk("b2b_lasts", 512'(lasts), 512'(4));
    chk("b2b_ars", 512'(ar_count), 512'(4));

    // random output backpressure and AR ready
    rnd_mode = 1'b1;
    send_cmd(64'h0, 33'h0);
    send_cmd(64'h0, 33'h0);
    wait_words(48);
    rnd_mode = 1'b0;
    chk("bp_lasts", 512'(lasts), 512'(6));

    // upper command bits dropped; optional burst alignment
`ifdef CHANNEL_READER_ADDR_ALIGN_EN
    send_cmd(64'h0001_2345_6789_ABCD, 33'h1_6789_AA00);
`else
    send_cmd(64'h0001_2345_6789_ABCD, 33'h1_6789_ABCD);
`endif
    wait_words(56);
    chk("addr_lasts", 512'(lasts), 512'(7));

    // reset in the middle of a burst, right after beat 5
    send_cmd(64'h0, 33'h0);
    n = 0;
    while (!(slv_active && slv_beat == 6) && n < 2000) begin
      tick();
      n++;
    end
    chk("mid_reached_beat6", 512'(slv_beat), 512'(6));
    reset = 1'b1;
    tick();
    chk("mid_ar_valid", 512'(io_ar_valid), 512'(0));
    chk("mid_out_valid", 512'(io_out_valid), 512'(0));
    chk("mid_r_ready", 512'(io_r_ready), 512'(0));
    chk("mid_cmd_ready", 512'(io_cmd_in_ready), 512'(0));
    chk("mid_out_data", io_out_bits_data, 512'(0));
    exp_q.delete();
    outstanding = 0;
    slv_stale   = 1'b1;
    reset       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stale_r_ready", 512'(io_r_ready), 512'(0));
    end
    chk("post_rst_idle", 512'(io_cmd_in_ready), 512'(1));
    base_words = out_words;
    send_cmd(64'h0, 33'h0);
    wait_words(base_words + 8);
    for (int i = 0; i < 4; i++) tick();
    chk("final_queue_empty", 512'(exp_q.size()), 512'(0));
    chk("final_ars", 512'(ar_count), 512'(9));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
